// File: rtl/sccb_pkg.sv
// Shared types and framing constants for the SCCB burst master.
package sccb_pkg;

    typedef enum logic [1:0] {
        MODE_W3   = 2'b00,
        MODE_W2   = 2'b01,
        MODE_RSVD = 2'b10,
        MODE_RD   = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        ID    = 4'd2,
        SUB   = 4'd3,
        WDATA = 4'd4,
        RDATA = 4'd5,
        STOP  = 4'd6,
        GUARD = 4'd7
    } state_t;

    localparam int unsigned QUARTERS_PER_BIT = 4;
    localparam int unsigned BITS_PER_PHASE   = 9;
    localparam int unsigned START_Q          = 4;
    localparam int unsigned STOP_Q           = 4;
    localparam int unsigned GUARD_Q          = 4;

endpackage

// File: rtl/sccb_qtick.sv
// Quarter-period tick generator; the counter rests at 0 while disabled.
module sccb_qtick #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign o_tick = i_en && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!i_en || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sccb_burst_master.sv
// SCCB burst master: 3-phase/2-phase writes and burst reads with quarter-bit pin timing.
// Optional ACK checking on master-transmit phases is enabled by defining SCCB_ACK_CHECK_EN.
module sccb_burst_master
    import sccb_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 250,
    parameter int unsigned MAX_BYTES = 4,
    localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_usher,
    input  logic [7:0]             i_address,
    input  logic [7:0]             i_subaddress,
    input  logic [8*MAX_BYTES-1:0] i_data,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [1:0]             i_mode,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [8*MAX_BYTES-1:0] o_rdata,
    output logic                   o_nack,
    inout  wire                    io_sda,
    output logic                   o_scl,
    output logic [3:0]             d_state
);
    state_t state, state_n;
    logic [1:0]       q, q_n;
    logic [3:0]       b, b_n;
    logic [LEN_W-1:0] idx, idx_n;

    logic [7:0]             id_l, sub_l, tx_byte, rx_sh;
    logic [8*MAX_BYTES-1:0] data_l, rx_buf;
    logic [LEN_W-1:0]       len_l;
    mode_t                  mode_l;

    logic tick, accept, sample, phase_end, last_byte, guard_end, nack_hit;
    logic sda_oe, sda_oe_n, scl_n, sda_in;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0) return LEN_W'(1);
        if (l > LEN_W'(MAX_BYTES)) return LEN_W'(MAX_BYTES);
        return l;
    endfunction

    assign accept    = (state == IDLE) && !o_busy && i_usher && (i_mode != MODE_RSVD);
    assign sample    = tick && (q == 2'd2);
    assign phase_end = tick && (q == 2'(QUARTERS_PER_BIT - 1)) && (b == 4'(BITS_PER_PHASE - 1));
    assign guard_end = tick && (state == GUARD) && (q == 2'(GUARD_Q - 1));
    assign last_byte = (idx == len_l - LEN_W'(1));
    assign sda_in    = io_sda;
    assign io_sda    = sda_oe ? 1'b0 : 1'bz;
    assign d_state   = state;

    sccb_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_en    ((state != IDLE) || accept),
        .o_tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            q     <= '0;
            b     <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            q     <= q_n;
            b     <= b_n;
            idx   <= idx_n;
        end
    end

    // Position advances one quarter per tick; phase boundaries pick the next phase.
    always_comb begin
        state_n = state;
        q_n     = q;
        b_n     = b;
        idx_n   = idx;
        if (accept) begin
            state_n = START;
            q_n     = '0;
            b_n     = '0;
            idx_n   = '0;
        end else if (tick) begin
            q_n = q + 2'd1;
            case (state)
                START: if (q == 2'(START_Q - 1)) state_n = ID;
                ID, SUB, WDATA, RDATA: begin
                    if (q == 2'(QUARTERS_PER_BIT - 1)) begin
                        if (b != 4'(BITS_PER_PHASE - 1)) begin
                            b_n = b + 4'd1;
                        end else begin
                            b_n = '0;
                            if (nack_hit) begin
                                state_n = STOP;
                            end else begin
                                case (state)
                                    ID:      state_n = (mode_l == MODE_RD) ? RDATA : SUB;
                                    SUB:     state_n = (mode_l == MODE_W3) ? WDATA : STOP;
                                    default: begin
                                        if (last_byte) state_n = STOP;
                                        else           idx_n   = idx + LEN_W'(1);
                                    end
                                endcase
                            end
                        end
                    end
                end
                STOP:    if (q == 2'(STOP_Q - 1)) state_n = GUARD;
                GUARD:   if (q == 2'(GUARD_Q - 1)) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state_n)
            ID:    tx_byte = id_l;
            SUB:   tx_byte = sub_l;
            WDATA: begin
                for (int k = 0; k < int'(MAX_BYTES); k++) begin
                    if (idx_n == LEN_W'(k)) tx_byte = data_l[8*k +: 8];
                end
            end
            default: tx_byte = 8'h00;
        endcase
    end

    // Pin levels for the quarter being entered; only changes across a tick.
    always_comb begin
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
        case (state_n)
            START: begin
                scl_n    = (q_n != 2'd3);
                sda_oe_n = (q_n != 2'd0);
            end
            ID, SUB, WDATA: begin
                scl_n = q_n[1];
                if (b_n < 4'd8) sda_oe_n = !tx_byte[3'(4'd7 - b_n)];
            end
            RDATA: begin
                scl_n    = q_n[1];
                sda_oe_n = (b_n == 4'd8) && (idx_n != len_l - LEN_W'(1));
            end
            STOP: begin
                scl_n    = (q_n != 2'd0);
                sda_oe_n = (q_n != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            o_scl   <= 1'b1;
            sda_oe  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_rdata <= '0;
            id_l    <= '0;
            sub_l   <= '0;
            data_l  <= '0;
            len_l   <= '0;
            mode_l  <= MODE_W3;
            rx_sh   <= '0;
            rx_buf  <= '0;
        end else begin
            o_scl  <= scl_n;
            sda_oe <= sda_oe_n;
            o_done <= guard_end;
            if (accept) begin
                id_l   <= (i_address & 8'hFE) | {7'd0, i_mode == MODE_RD};
                sub_l  <= i_subaddress;
                data_l <= i_data;
                len_l  <= clamp_len(i_len);
                mode_l <= mode_t'(i_mode);
                rx_buf <= '0;
                o_busy <= 1'b1;
            end else if (o_done) begin
                o_busy <= 1'b0;
            end
            if (sample && (state == RDATA) && (b < 4'd8)) rx_sh <= {rx_sh[6:0], sda_in};
            if (phase_end && (state == RDATA)) begin
                for (int k = 0; k < int'(MAX_BYTES); k++) begin
                    if (idx == LEN_W'(k)) rx_buf[8*k +: 8] <= rx_sh;
                end
            end
            if (guard_end && (mode_l == MODE_RD)) o_rdata <= rx_buf;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic nack_pend;

    // ACK slot sampled on the high half of bit 9; a released line aborts to STOP.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            nack_pend <= 1'b0;
            o_nack    <= 1'b0;
        end else if (accept) begin
            nack_pend <= 1'b0;
            o_nack    <= 1'b0;
        end else begin
            if (sample && (b == 4'd8) && (state inside {ID, SUB, WDATA}) && sda_in)
                nack_pend <= 1'b1;
            if (guard_end) o_nack <= nack_pend;
        end
    end

    assign nack_hit = nack_pend;
`else
    assign nack_hit = 1'b0;
    assign o_nack   = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_burst_master.sv
// Directed bench for sccb_burst_master with a bus monitor and a simple SCCB slave model.
module tb_sccb_burst_master;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned MAX_BYTES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        usher;
    logic [7:0]  address, subaddress;
    logic [31:0] data;
    logic [2:0]  len;
    logic [1:0]  mode;
    logic        busy, done, nack, scl;
    logic [31:0] rdata;
    logic [3:0]  state;
    wire         sda;

    pullup (sda);

    logic slave_drv = 1'b0;
    assign sda = slave_drv ? 1'b0 : 1'bz;

    sccb_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_usher      (usher),
        .i_address    (address),
        .i_subaddress (subaddress),
        .i_data       (data),
        .i_len        (len),
        .i_mode       (mode),
        .o_busy       (busy),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_nack       (nack),
        .io_sda       (sda),
        .o_scl        (scl),
        .d_state      (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration (written by the stimulus only)
    logic [7:0] rd_bytes [0:3];
    int         rd_cnt;
    logic       nack_inject;

    // Monitor state (written by the monitor only)
    logic [7:0] wbytes [0:15];
    logic       wbit9  [0:15];
    int         nwb = 0, bitn = 0, starts = 0, stops = 0, dones = 0, busy_cyc = 0;
    logic [7:0] sh = 8'h00;
    logic       in_xfer = 1'b0, pscl = 1'b1, psda = 1'b1;

    // Pins only move on posedge, so negedge sampling sees settled levels.
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) dones++;
        if (pscl && scl && psda && !sda) begin
            starts++;
            in_xfer   = 1'b1;
            nwb       = 0;
            bitn      = 0;
            slave_drv = 1'b0;
        end else if (pscl && scl && !psda && sda) begin
            if (in_xfer) stops++;
            in_xfer   = 1'b0;
            slave_drv = 1'b0;
        end else if (in_xfer && !pscl && scl) begin
            if (bitn < 8) begin
                sh = {sh[6:0], sda};
            end else begin
                if (nwb < 16) begin
                    wbytes[nwb] = sh;
                    wbit9[nwb]  = sda;
                end
                nwb++;
            end
            bitn = (bitn == 8) ? 0 : bitn + 1;
        end else if (in_xfer && pscl && !scl) begin
            if (nwb == 0) begin
                slave_drv = (bitn == 8) && !nack_inject;
            end else if (wbytes[0][0]) begin
                if (nwb <= rd_cnt && bitn < 8) slave_drv = !rd_bytes[nwb-1][7-bitn];
                else                           slave_drv = 1'b0;
            end else begin
                slave_drv = (bitn == 8) && !nack_inject;
            end
        end
        pscl = scl;
        psda = sda;
    end

    logic        got_done, done_busy, done_nack;
    logic [31:0] done_rdata;
    int          b0, d0, s0;

    task automatic start_txn(input logic [7:0] a, input logic [7:0] s, input logic [31:0] d,
                             input logic [2:0] l, input logic [1:0] m);
        @(negedge clk);
        address    = a;
        subaddress = s;
        data       = d;
        len        = l;
        mode       = m;
        usher      = 1'b1;
        b0 = busy_cyc;
        d0 = dones;
        s0 = stops;
        @(negedge clk);
        usher = 1'b0;
    endtask

    task automatic wait_done();
        got_done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done   = 1'b1;
                done_busy  = busy;
                done_nack  = nack;
                done_rdata = rdata;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] s, input logic [31:0] d,
                           input logic [2:0] l, input logic [1:0] m);
        start_txn(a, s, d, l, m);
        wait_done();
    endtask

    initial begin
        rst_n = 1'b0; usher = 1'b0; address = '0; subaddress = '0;
        data = '0; len = '0; mode = '0;
        rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
        rd_cnt = 0; nack_inject = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_scl",   scl,   1);
        check("rst_sda",   sda,   1);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_state", state, 0);
        check("rst_rdata", rdata, 0);
        check("rst_nack",  nack,  0);
        rst_n = 1'b1;

        // 3-phase write, one byte
        run_txn(8'h42, 8'h21, 32'h0000_00AB, 3'd1, 2'b00);
        check("w1_done",   got_done, 1);
        check("w1_nbytes", nwb, 3);
        check("w1_b0",     wbytes[0], 8'h42);
        check("w1_b1",     wbytes[1], 8'h21);
        check("w1_b2",     wbytes[2], 8'hAB);
        check("w1_busy",   busy_cyc - b0, 480);
        check("w1_pulses", dones - d0, 1);
        check("w1_stops",  stops - s0, 1);
        check("w1_busy_at_done", done_busy, 1);
        check("w1_idle",   state, 0);

        // 3-phase write, three bytes, byte 0 first
        run_txn(8'h42, 8'h21, 32'h00CC_BBAA, 3'd3, 2'b00);
        check("w3_nbytes", nwb, 5);
        check("w3_b2",     wbytes[2], 8'hAA);
        check("w3_b3",     wbytes[3], 8'hBB);
        check("w3_b4",     wbytes[4], 8'hCC);
        check("w3_busy",   busy_cyc - b0, 768);

        // 2-phase pointer write
        run_txn(8'h42, 8'h21, 32'h0000_00AB, 3'd1, 2'b01);
        check("p_nbytes", nwb, 2);
        check("p_b0",     wbytes[0], 8'h42);
        check("p_b1",     wbytes[1], 8'h21);
        check("p_busy",   busy_cyc - b0, 336);
        check("p_stops",  stops - s0, 1);

        // 2-phase read of two bytes
        rd_cnt = 2;
        run_txn(8'h43, 8'h00, 32'h0, 3'd2, 2'b11);
        check("r2_done",   got_done, 1);
        check("r2_nbytes", nwb, 3);
        check("r2_id",     wbytes[0], 8'h43);
        check("r2_d0",     wbytes[1], 8'h5A);
        check("r2_d1",     wbytes[2], 8'hC3);
        check("r2_ack0",   wbit9[1], 0);
        check("r2_na",     wbit9[2], 1);
        check("r2_rdata",  done_rdata, 32'h0000_C35A);
        check("r2_busy",   busy_cyc - b0, 480);

        // len 0 behaves as 1; a write leaves o_rdata alone
        run_txn(8'h42, 8'h10, 32'h0000_0011, 3'd0, 2'b00);
        check("l0_nbytes", nwb, 3);
        check("l0_b2",     wbytes[2], 8'h11);
        check("l0_busy",   busy_cyc - b0, 480);
        check("l0_rdata_hold", rdata, 32'h0000_C35A);

        // len above MAX_BYTES clamps to MAX_BYTES
        run_txn(8'h42, 8'h10, 32'h4433_2211, 3'd7, 2'b00);
        check("l7_nbytes", nwb, 6);
        check("l7_b5",     wbytes[5], 8'h44);
        check("l7_busy",   busy_cyc - b0, 912);

        // single-byte read zeroes the upper bytes
        rd_bytes[0] = 8'h96; rd_cnt = 1;
        run_txn(8'h43, 8'h00, 32'h0, 3'd1, 2'b11);
        check("r1_rdata", done_rdata, 32'h0000_0096);
        check("r1_na",    wbit9[1], 1);

        // reserved mode is ignored
        @(negedge clk);
        b0 = busy_cyc; s0 = starts;
        mode = 2'b10; usher = 1'b1;
        repeat (40) @(negedge clk);
        usher = 1'b0;
        check("rsvd_busy",   busy_cyc - b0, 0);
        check("rsvd_starts", starts - s0, 0);
        check("rsvd_state",  state, 0);

        // reset pulse during SUB bit 4, then a clean transaction
        start_txn(8'h42, 8'h21, 32'h0000_00AB, 3'd1, 2'b00);
        for (int i = 0; i < 1000 && state != 4'd3; i++) @(negedge clk);
        check("mid_in_sub", state, 3);
        repeat (4 * 4 * CLK_DIV + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_state", state, 0);
        check("mid_scl",   scl,   1);
        check("mid_sda",   sda,   1);
        check("mid_busy",  busy,  0);
        repeat (3) @(negedge clk);
        run_txn(8'h42, 8'h21, 32'h0000_005C, 3'd1, 2'b00);
        check("post_nbytes", nwb, 3);
        check("post_b1",     wbytes[1], 8'h21);
        check("post_b2",     wbytes[2], 8'h5C);
        check("post_busy",   busy_cyc - b0, 480);

        // slave never acknowledges
        nack_inject = 1'b1;
        run_txn(8'h42, 8'h21, 32'h0000_00AB, 3'd1, 2'b00);
        nack_inject = 1'b0;
        check("na_done",  got_done, 1);
        check("na_stops", stops - s0, 1);
`ifdef SCCB_ACK_CHECK_EN
        check("na_nack",   done_nack, 1);
        check("na_nbytes", nwb, 1);
        check("na_busy",   busy_cyc - b0, 192);
        run_txn(8'h42, 8'h21, 32'h0000_00AB, 3'd1, 2'b00);
        check("ack_nack",  done_nack, 0);
        check("ack_busy",  busy_cyc - b0, 480);
`else
        check("na_nack",   done_nack, 0);
        check("na_nbytes", nwb, 3);
        check("na_busy",   busy_cyc - b0, 480);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sccb_burst_master.md
Name: sccb_burst_master

Overview:
Parametrised second-generation SCCB master for OV7670 camera register configuration.
- Adds a configurable SCL divider, multi-byte burst writes and reads, a read-data return path, a done strobe and optional ACK checking.
- Sits between the register-init sequencer and the camera SIOC/SIOD pins. Drives o_scl push-pull and io_sda open-drain.

Parameters:
CLK_DIV, 250, clk cycles per SCL quarter-period (≥2); SCL period = 4*CLK_DIV
MAX_BYTES, 4, maximum data bytes per transaction (≥1)
LEN_W, $clog2(MAX_BYTES+1), width of i_len (derived, not overridden)

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_usher  in  1  start request; sampled only in IDLE
i_address  in  8  device ID; bit0 is replaced by R/W (0 write, 1 read)
i_subaddress  in  8  register address
i_data  in  8*MAX_BYTES  write bytes; byte k = [8k+7:8k], byte 0 sent first
i_len  in  LEN_W  data byte count; 0 is treated as 1, values >MAX_BYTES are treated as MAX_BYTES
i_mode  in  2  00 3-phase write, 01 2-phase write (pointer set), 11 2-phase read, 10 reserved
o_busy  out  1  transaction in progress
o_done  out  1  one-cycle pulse at completion
o_rdata  out  8*MAX_BYTES  read bytes, same byte order as i_data
o_nack  out  1  ACK failure flag (see Optional Feature)
io_sda  inout  1  driven 0 or released to Z; never driven 1
o_scl  out  1  SCL
d_state  out  4  current FSM state encoding, for debug

Behaviour:
- Reset values: o_scl=1, io_sda=Z, o_busy=0, o_done=0, o_rdata=0, o_nack=0, d_state=IDLE(0), divider=0.
- Reset asserted mid-transfer: IDLE on the next edge; SCL=1 and SDA released immediately; no STOP sequence is generated.
- Acceptance: in IDLE with i_usher=1 and i_mode≠10, latch all inputs and assert o_busy on the next cycle. A held i_usher starts back-to-back transactions. Mode 10 is ignored with no bus activity.
- Divider: counter 0..CLK_DIV-1; a quarter tick is generated at CLK_DIV-1. All FSM and pin changes occur only on ticks.
- Bit timing, 4 quarters per bit:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2: SCL high; read sample taken on the tick ending Q2.
  - Q3: SCL high.
- States: IDLE(0), START(1), ID(2), SUB(3), WDATA(4), RDATA(5), STOP(6), GUARD(7).
- START: 4 quarters. SDA falls while SCL is high (2Q), then SCL falls.
- Phases: 9 bits each, MSB first.
  - Master-transmit phases (ID, SUB, WDATA): bit 9 is a don't-care with SDA released.
  - RDATA: master releases SDA for bits 1-8, then drives bit 9 as 0 after non-last bytes and releases it (NA=1) after the last byte.
- Sequence per mode:
  - 00: ID(w), SUB, WDATA×len
  - 01: ID(w), SUB
  - 11: ID(r), RDATA×len
- STOP: 4 quarters. SCL low/SDA low, SCL high, then SDA released after 2Q.
- GUARD: 4 quarters of bus idle, then o_done=1 for one cycle. o_busy falls on the following cycle.
- Duration: busy cycles = CLK_DIV*(12 + 36*phases), where phases = 2+len (mode 00), 2 (mode 01), 1+len (mode 11).
- Read data: shifted into an internal register and copied to o_rdata in the o_done cycle. Bytes at index ≥len are zero. o_rdata holds its value until the next read completes.

Optional Feature:
Macro SCCB_ACK_CHECK_EN.
- Defined:
  - Sample SDA at bit 9 of ID/SUB/WDATA.
  - If SDA=1, set o_nack and jump to STOP after that phase.
  - o_nack is cleared at acceptance and valid from the o_done cycle until the next acceptance.
- Undefined: o_nack tied 0; bit 9 is ignored (pure SCCB).

Decomposition:
- sccb_pkg:
  - mode enum (MODE_W3, MODE_W2, MODE_RD, MODE_RSVD)
  - state enum with the fixed encodings above
  - constants QUARTERS_PER_BIT=4, BITS_PER_PHASE=9, START_Q=4, STOP_Q=4, GUARD_Q=4
- Sub-module sccb_qtick: parametrised quarter-tick divider (clk, i_rst_n, i_en → o_tick). Counter is held at 0 when i_en=0.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles → o_scl=1, io_sda=Z (pulled to 1), o_busy=0, d_state=0.
- CLK_DIV=4, mode 00, addr 0x42, sub 0x21, data 0xAB, len 1 → wire bytes 42,21,AB; o_busy high for exactly 480 cycles; single o_done pulse.
- Mode 00, len 3, i_data=0x00CCBBAA → wire bytes 42,21,AA,BB,CC; mode 01 → 42,21 then STOP.
- Mode 11, addr 0x43, len 2; bench slave drives 0x5A then 0xC3 → ID byte 0x43; master bit 9 = 0 then released; o_rdata=0x0000C35A at o_done.
- Assert i_rst_n=0 for 1 cycle during SUB bit 4 → next cycle IDLE, SCL=1, SDA=Z; next i_usher runs a clean full transaction.
- With SCCB_ACK_CHECK_EN, slave leaves SDA high at ID bit 9 → SUB skipped; STOP and GUARD follow; o_nack=1 at o_done; total 4*(12+36)=192 cycles.
